// File: rtl/demux_1x2x32.sv
// 1:2 valid/ready stream demux with an independent FIFO per output.
// Optional per-output push counters: define DEMUX_CNT_EN.
module demux_1x2x32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_FW = $clog2(DEPTH + 1);

  // Index 0 is output A, index 1 is output B.
  logic [WIDTH-1:0]  r_mem    [2][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [2];
  logic [PTR_W-1:0]  r_rd_ptr [2];
  logic [CNT_FW-1:0] r_cnt    [2];

  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_valid;
  logic [CNT_FW-1:0] w_cnt_sel;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // in_ready looks only at registered occupancy, so a full FIFO stays
  // closed even when its consumer pops in the same cycle.
  assign w_cnt_sel  = in_sel ? r_cnt[1] : r_cnt[0];
  assign in_ready   = (w_cnt_sel < CNT_FW'(DEPTH));
  assign w_push[0]  = in_valid && in_ready && !in_sel;
  assign w_push[1]  = in_valid && in_ready && in_sel;
  assign w_valid[0] = (r_cnt[0] != '0);
  assign w_valid[1] = (r_cnt[1] != '0);
  assign w_pop      = w_valid & {b_ready, a_ready};

  assign a_valid = w_valid[0];
  assign b_valid = w_valid[1];
  assign a_data  = w_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
  assign b_data  = w_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < 2; f++) begin
        r_wr_ptr[f] <= '0;
        r_rd_ptr[f] <= '0;
        r_cnt[f]    <= '0;
      end
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (w_push[f]) r_wr_ptr[f] <= f_next(r_wr_ptr[f]);
        if (w_pop[f])  r_rd_ptr[f] <= f_next(r_rd_ptr[f]);
        case ({w_push[f], w_pop[f]})
          2'b10:   r_cnt[f] <= r_cnt[f] + CNT_FW'(1);
          2'b01:   r_cnt[f] <= r_cnt[f] - CNT_FW'(1);
          default: r_cnt[f] <= r_cnt[f];
        endcase
      end
    end
  end

  // Storage is not reset; stale contents are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int f = 0; f < 2; f++) begin
        if (w_push[f]) r_mem[f][r_wr_ptr[f]] <= in_data;
      end
    end
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] r_count [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count[0] <= '0;
      r_count[1] <= '0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        if (w_push[f]) r_count[f] <= r_count[f] + CNT_W'(1);
      end
    end
  end

  assign a_count = r_count[0];
  assign b_count = r_count[1];
`endif

endmodule

// File: tb/tb_demux_1x2x32.sv
// Bench for demux_1x2x32: vector table, corner sequences and a two-queue
// scoreboard that tracks both outputs every cycle.
module tb_demux_1x2x32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
`ifdef DEMUX_CNT_EN
  logic [3:0]  a_count;
  logic [3:0]  b_count;
`endif

  demux_1x2x32 #(
    .WIDTH(32),
    .DEPTH(DEPTH)
`ifdef DEMUX_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DEMUX_CNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [3:0]  m_ca = '0;
  logic [3:0]  m_cb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [31:0] d,
                       input logic ar, input logic br);
    rst = r; in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs seen at the falling edge are those the next rising edge consumes.
  always @(negedge clk) begin
    logic exp_rdy;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      m_ca = '0;
      m_cb = '0;
    end else if (mon_en) begin
      exp_rdy = in_sel ? (q_b.size() < DEPTH) : (q_a.size() < DEPTH);
      chk("sb_in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("sb_a_valid", {31'b0, a_valid}, {31'b0, q_a.size() != 0});
      chk("sb_a_data", a_data, (q_a.size() != 0) ? q_a[0] : 32'h0);
      chk("sb_b_valid", {31'b0, b_valid}, {31'b0, q_b.size() != 0});
      chk("sb_b_data", b_data, (q_b.size() != 0) ? q_b[0] : 32'h0);
`ifdef DEMUX_CNT_EN
      chk("sb_a_count", {28'b0, a_count}, {28'b0, m_ca});
      chk("sb_b_count", {28'b0, b_count}, {28'b0, m_cb});
`endif
      if (a_ready && q_a.size() != 0) void'(q_a.pop_front());
      if (b_ready && q_b.size() != 0) void'(q_b.pop_front());
      if (in_valid && exp_rdy) begin
        if (in_sel) begin q_b.push_back(in_data); m_cb = m_cb + 4'd1; end
        else        begin q_a.push_back(in_data); m_ca = m_ca + 4'd1; end
      end
    end
  end

  typedef struct {
    logic        vld;
    logic        sel;
    logic [31:0] data;
    logic        ar;
    logic        br;
    logic        exp_rdy;   // before the edge
    logic        exp_av;    // after the edge
    logic [31:0] exp_ad;
    logic        exp_bv;
    logic [31:0] exp_bd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    bit accepted;
    int budget;

    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'hAAAA_0001, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'hAAAA_0002, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA_0002, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 1'b1, 32'hBBBB_BBBB};
    tbl[12] = '{1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};

    // Reset, then idle
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    mon_en = 1'b1;
    chk("rst_a_valid", {31'b0, a_valid}, 32'h0);
    chk("rst_a_data", a_data, 32'h0);
    chk("rst_b_valid", {31'b0, b_valid}, 32'h0);
    chk("rst_b_data", b_data, 32'h0);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].ar, tbl[i].br);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].exp_rdy});
      tick();
      chk($sformatf("vec%0d_a_valid", i), {31'b0, a_valid}, {31'b0, tbl[i].exp_av});
      chk($sformatf("vec%0d_a_data", i), a_data, tbl[i].exp_ad);
      chk($sformatf("vec%0d_b_valid", i), {31'b0, b_valid}, {31'b0, tbl[i].exp_bv});
      chk($sformatf("vec%0d_b_data", i), b_data, tbl[i].exp_bd);
    end

    // Fill both FIFOs, then reset with a push presented in the reset cycle
    drive(1'b0, 1'b1, 1'b0, 32'hC0DE_0001, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 32'hC0DE_0002, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'hC0DE_0003, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 32'hC0DE_0004, 1'b0, 1'b0); tick();
    chk("full_a_valid", {31'b0, a_valid}, 32'h1);
    chk("full_b_data", b_data, 32'hC0DE_0003);
    drive(1'b1, 1'b1, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("mid_rst_a_valid", {31'b0, a_valid}, 32'h0);
    chk("mid_rst_b_valid", {31'b0, b_valid}, 32'h0);
    chk("mid_rst_a_data", a_data, 32'h0);
    chk("mid_rst_b_data", b_data, 32'h0);
    @(negedge clk);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_a", {31'b0, a_valid}, 32'h0);
      chk("post_rst_no_b", {31'b0, b_valid}, 32'h0);
    end

    // Random mixed traffic against the scoreboard
    for (int w = 0; w < 12; w++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      accepted = 1'b0;
      budget = 0;
      while (!accepted && budget < 50) begin
        @(negedge clk);
        accepted = in_ready;
        tick();
        budget++;
        if (!accepted) begin
          a_ready = 1'($urandom_range(0, 1));
          b_ready = 1'($urandom_range(0, 1));
        end
      end
      if (!accepted) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_accept: word %0d not accepted within 50 cycles", w);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    chk("drain_q_a", q_a.size(), 32'h0);
    chk("drain_q_b", q_b.size(), 32'h0);
    chk("drain_a_valid", {31'b0, a_valid}, 32'h0);
    chk("drain_b_valid", {31'b0, b_valid}, 32'h0);

`ifdef DEMUX_CNT_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("cnt_rst_a", {28'b0, a_count}, 32'h0);
    chk("cnt_rst_b", {28'b0, b_count}, 32'h0);
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, 1'b1, 1'b1, 32'h5000_0000 + k, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    chk("cnt_wrap_b", {28'b0, b_count}, 32'h1);
    chk("cnt_wrap_a", {28'b0, a_count}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_1x2x32.md
Name: demux_1x2x32

Overview:
Stream demultiplexer, the inverse of the 2:1 32-bit select mux. One valid/ready input stream is routed to output A (sel=0) or output B (sel=1). Each output has its own small FIFO so a stalled output does not block traffic to the other. It sits between a single producer and two consumer datapaths.

Parameters:
WIDTH  32  data width of input and both outputs
DEPTH  2   entries per output FIFO; legal range 1..16
CNT_W  16  width of the transfer counters (only used when DEMUX_CNT_EN is defined)

Ports:
clk       input   1      single clock; all state updates on the rising edge
rst       input   1      synchronous, active-high reset
in_data   input   WIDTH  payload
in_sel    input   1      route select: 0 = A, 1 = B; sampled with in_data
in_valid  input   1      producer has a word
in_ready  output  1      demux accepts the word this cycle
a_data    output  WIDTH  head of FIFO A
a_valid   output  1      FIFO A is non-empty
a_ready   input   1      consumer A takes the head
b_data    output  WIDTH  head of FIFO B
b_valid   output  1      FIFO B is non-empty
b_ready   input   1      consumer B takes the head

Behaviour:
- Push: occurs when in_valid && in_ready. The word is written to the FIFO selected by in_sel at the tail.
- in_ready = (in_sel ? cnt_b : cnt_a) < DEPTH.
  - Registered counts only. There is no combinational path from a_ready or b_ready to in_ready.
  - A full FIFO deasserts in_ready even if it pops in the same cycle.
- Pop: occurs when x_valid && x_ready. The head advances on the next clock edge.
- x_valid = (cnt_x != 0).
- x_data = mem_x[rd_ptr_x] when x_valid; it is 0 when the FIFO is empty.
- Latency: a word pushed at edge N is visible on x_data/x_valid after edge N. Minimum one cycle in to out; no combinational bypass.
- Per FIFO state: wr_ptr, rd_ptr, cnt.
  - Pointers wrap DEPTH-1 -> 0. DEPTH need not be a power of two.
  - Push only: cnt+1. Pop only: cnt-1. Push and pop in the same cycle: cnt unchanged, both pointers advance.
- Ordering: FIFO order is preserved within each output. There is no ordering relation between A and B.
- in_valid=0: no push, regardless of in_sel and in_data.
- Pop while empty is impossible because x_valid=0. x_ready is ignored when x_valid=0.
- Reset (synchronous, rst=1 at an edge):
  - All cnt and pointers go to 0.
  - a_valid = b_valid = 0, a_data = b_data = 0.
  - in_ready is 1 in the cycle after reset.
  - Reset mid-operation discards all buffered words. A push presented in the reset cycle is dropped.
  - in_ready is not guaranteed while rst=1 and the bench must not count that cycle as a transfer.
- Outputs never go X after reset. Memory contents are not reset, but they are masked by the empty rule.

Optional Feature:
Macro DEMUX_CNT_EN.
- Defined:
  - Adds output ports a_count and b_count [CNT_W-1:0].
  - Each counts accepted pushes to its FIFO.
  - Reset to 0 and wrap from 2^CNT_W-1 to 0.
  - A count updates on the same edge as the push.
- Undefined: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then idle: a_valid=b_valid=0, a_data=b_data=0, in_ready=1.
2. Push 32'h0000_0000 with sel=0 and 32'hFFFF_FFFF with sel=1, both readys=1:
   - A shows 00000000 and B shows FFFFFFFF, one cycle after the respective push.
   - Each pops on the next edge.
3. Backpressure, a_ready=0, DEPTH=2, push sel=0 with 32'h1111_1111, 32'h2222_2222, 32'h3333_3333:
   - The third word waits with in_ready=0.
   - A push with sel=1 of 32'hBBBB_BBBB is still accepted immediately.
   - Raising a_ready drains 1111..., 2222..., 3333... in order.
4. FIFO A at cnt=1 with head 32'hAAAA_0001; in the same cycle a_ready=1 and a push with sel=0 of 32'hAAAA_0002:
   - cnt stays 1.
   - a_data becomes AAAA0002 the next cycle.
5. Reset mid-stream with both FIFOs full and rst=1 for one cycle: next cycle both valids=0, in_ready=1, and previously buffered data is never emitted.
6. DEMUX_CNT_EN with CNT_W=4: 17 pushes with sel=1 give b_count=1 (wrapped) and a_count=0. Random 12-word mixed-sel traffic is compared against a two-queue golden model.
